// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, mul/div sequencer state encoding and operand-match helper
// for the five-stage pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int ADDR_BUS_W = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_START = 2'd1,
        MD_BUSY  = 2'd2
    } mdState_e;

    // An Id source operand depends on rd only when it is actually read.
    function automatic logic regMatch(
        input logic                  readEn,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd
    );
        return readEn & (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use detector: the Id instruction needs a register that the load
// currently in Ex has not yet fetched from memory.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic                  LoadInEx,
    input  logic                  RdWriteEnableEx,
    input  logic [REG_ADDR_W-1:0] RdAddrEx,
    input  logic [REG_ADDR_W-1:0] Rs1AddrId,
    input  logic [REG_ADDR_W-1:0] Rs2AddrId,
    input  logic                  Rs1ReadEnableId,
    input  logic                  Rs2ReadEnableId,
    output logic                  LoadUse
);

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    always_comb begin
        LoadUse = 1'b0;
        if (LoadInEx && RdWriteEnableEx && (RdAddrEx != {REG_ADDR_W{1'b0}})) begin
            LoadUse = regMatch(Rs1ReadEnableId, Rs1AddrId, RdAddrEx)
                    | regMatch(Rs2ReadEnableId, Rs2AddrId, RdAddrEx);
        end else begin
            LoadUse = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: arbitrates memory wait, mul/div,
// jump and load-use requests into per-stage hold/flush controls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_BUS_W,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  JumpFlagFromEx,
    input  logic [ADDR_W-1:0]     JumpAddrFromEx,
    input  logic                  LoadInEx,
    input  logic [REG_ADDR_W-1:0] RdAddrEx,
    input  logic                  RdWriteEnableEx,
    input  logic [REG_ADDR_W-1:0] Rs1AddrId,
    input  logic [REG_ADDR_W-1:0] Rs2AddrId,
    input  logic                  Rs1ReadEnableId,
    input  logic                  Rs2ReadEnableId,
    input  logic                  MdReqEx,
    input  logic                  MdDoneIn,
    input  logic                  MemReqIn,
    input  logic                  MemReadyIn,
    output logic                  MdStartOut,
    output logic                  StallPc,
    output logic                  StallIf2Id,
    output logic                  StallId2Ex,
    output logic                  StallEx2Mem,
    output logic                  FlushIf2Id,
    output logic                  BubbleId2Ex,
    output logic                  BubbleEx2Mem,
    output logic                  BubbleMem2Wb,
    output logic                  JumpFlagToPc,
    output logic [ADDR_W-1:0]     JumpAddrToPc,
    output logic                  MdTimeout,
    output logic [CNT_W-1:0]      StallCycles
);

    localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [MD_CNT_W-1:0] MD_LIMIT   = MD_CNT_W'(MD_TIMEOUT);
    localparam logic [MD_CNT_W-1:0] MD_CNT_ONE = MD_CNT_W'(1'b1);
    localparam logic [MD_CNT_W-1:0] MD_CNT_ZERO = {MD_CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    STALL_ONE  = CNT_W'(1'b1);

    mdState_e              state_r;
    mdState_e              nextState_s;
    logic [MD_CNT_W-1:0]   mdCnt_r;
    logic [MD_CNT_W-1:0]   mdCntNext_s;
    logic [MD_CNT_W-1:0]   mdCntInc_s;
    logic                  timeoutHit_s;
    logic                  mdTimeout_r;
    logic [CNT_W-1:0]      stallCycles_r;
    logic                  memWait_s;
    logic                  mdHold_s;
    logic                  loadUse_s;

    pipe_ctrl_hazard u_hazard (
        .LoadInEx        (LoadInEx),
        .RdWriteEnableEx (RdWriteEnableEx),
        .RdAddrEx        (RdAddrEx),
        .Rs1AddrId       (Rs1AddrId),
        .Rs2AddrId       (Rs2AddrId),
        .Rs1ReadEnableId (Rs1ReadEnableId),
        .Rs2ReadEnableId (Rs2ReadEnableId),
        .LoadUse         (loadUse_s)
    );

    assign memWait_s  = MemReqIn & ~MemReadyIn;
    // The done cycle releases the pipeline so the mul/div result advances out of Ex.
    assign mdHold_s   = ((state_r != MD_IDLE) | MdReqEx) & ~((state_r == MD_BUSY) & MdDoneIn);
    assign mdCntInc_s = mdCnt_r + MD_CNT_ONE;

    // Mul/div sequencer next state. A memory wait only blocks a new launch;
    // an operation already issued keeps running so its done pulse is not lost.
    always_comb begin
        nextState_s  = state_r;
        mdCntNext_s  = mdCnt_r;
        timeoutHit_s = 1'b0;
        case (state_r)
            MD_IDLE: begin
                mdCntNext_s = MD_CNT_ZERO;
                if (MdReqEx && !memWait_s) begin
                    nextState_s = MD_START;
                end else begin
                    nextState_s = MD_IDLE;
                end
            end
            MD_START: begin
                nextState_s = MD_BUSY;
                mdCntNext_s = MD_CNT_ZERO;
            end
            MD_BUSY: begin
                if (MdDoneIn) begin
                    nextState_s = MD_IDLE;
                    mdCntNext_s = MD_CNT_ZERO;
                end else if (mdCntInc_s == MD_LIMIT) begin
                    timeoutHit_s = 1'b1;
                    nextState_s  = MD_IDLE;
                    mdCntNext_s  = MD_CNT_ZERO;
                end else begin
                    mdCntNext_s = mdCntInc_s;
                end
            end
            default: begin
                nextState_s = MD_IDLE;
                mdCntNext_s = MD_CNT_ZERO;
            end
        endcase
    end

    // Priority mux: memory wait, then mul/div hold, then jump, then load-use.
    always_comb begin
        MdStartOut   = (state_r == MD_START);
        StallPc      = 1'b0;
        StallIf2Id   = 1'b0;
        StallId2Ex   = 1'b0;
        StallEx2Mem  = 1'b0;
        FlushIf2Id   = 1'b0;
        BubbleId2Ex  = 1'b0;
        BubbleEx2Mem = 1'b0;
        BubbleMem2Wb = 1'b0;
        JumpFlagToPc = 1'b0;
        JumpAddrToPc = {ADDR_W{1'b0}};
        if (memWait_s) begin
            StallPc      = 1'b1;
            StallIf2Id   = 1'b1;
            StallId2Ex   = 1'b1;
            StallEx2Mem  = 1'b1;
            BubbleMem2Wb = 1'b1;
        end else if (mdHold_s) begin
            StallPc      = 1'b1;
            StallIf2Id   = 1'b1;
            StallId2Ex   = 1'b1;
            BubbleEx2Mem = 1'b1;
        end else if (JumpFlagFromEx) begin
            JumpFlagToPc = 1'b1;
            JumpAddrToPc = JumpAddrFromEx;
            FlushIf2Id   = 1'b1;
            BubbleId2Ex  = 1'b1;
        end else begin
            StallPc     = loadUse_s;
            StallIf2Id  = loadUse_s;
            BubbleId2Ex = loadUse_s;
        end
    end

    // Sequencer state and busy-cycle counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= MD_IDLE;
            mdCnt_r <= MD_CNT_ZERO;
        end else begin
            state_r <= nextState_s;
            mdCnt_r <= mdCntNext_s;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mdTimeout_r <= 1'b0;
        end else begin
            mdTimeout_r <= mdTimeout_r | timeoutHit_s;
        end
    end

    // Free-running count of Pc-stall cycles, wrapping at full width.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stallCycles_r <= {CNT_W{1'b0}};
        end else if (StallPc) begin
            stallCycles_r <= stallCycles_r + STALL_ONE;
        end else begin
            stallCycles_r <= stallCycles_r;
        end
    end

    assign MdTimeout   = mdTimeout_r;
    assign StallCycles = stallCycles_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic,
// checked every cycle against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int ADDR_W     = 64;
    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 8;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              JumpFlagFromEx;
    logic [ADDR_W-1:0] JumpAddrFromEx;
    logic              LoadInEx;
    logic [4:0]        RdAddrEx;
    logic              RdWriteEnableEx;
    logic [4:0]        Rs1AddrId;
    logic [4:0]        Rs2AddrId;
    logic              Rs1ReadEnableId;
    logic              Rs2ReadEnableId;
    logic              MdReqEx;
    logic              MdDoneIn;
    logic              MemReqIn;
    logic              MemReadyIn;
    logic              MdStartOut;
    logic              StallPc;
    logic              StallIf2Id;
    logic              StallId2Ex;
    logic              StallEx2Mem;
    logic              FlushIf2Id;
    logic              BubbleId2Ex;
    logic              BubbleEx2Mem;
    logic              BubbleMem2Wb;
    logic              JumpFlagToPc;
    logic [ADDR_W-1:0] JumpAddrToPc;
    logic              MdTimeout;
    logic [CNT_W-1:0]  StallCycles;

    pipe_ctrl #(.ADDR_W(ADDR_W), .MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .JumpFlagFromEx(JumpFlagFromEx), .JumpAddrFromEx(JumpAddrFromEx),
        .LoadInEx(LoadInEx), .RdAddrEx(RdAddrEx), .RdWriteEnableEx(RdWriteEnableEx),
        .Rs1AddrId(Rs1AddrId), .Rs2AddrId(Rs2AddrId),
        .Rs1ReadEnableId(Rs1ReadEnableId), .Rs2ReadEnableId(Rs2ReadEnableId),
        .MdReqEx(MdReqEx), .MdDoneIn(MdDoneIn), .MemReqIn(MemReqIn), .MemReadyIn(MemReadyIn),
        .MdStartOut(MdStartOut), .StallPc(StallPc), .StallIf2Id(StallIf2Id),
        .StallId2Ex(StallId2Ex), .StallEx2Mem(StallEx2Mem), .FlushIf2Id(FlushIf2Id),
        .BubbleId2Ex(BubbleId2Ex), .BubbleEx2Mem(BubbleEx2Mem), .BubbleMem2Wb(BubbleMem2Wb),
        .JumpFlagToPc(JumpFlagToPc), .JumpAddrToPc(JumpAddrToPc),
        .MdTimeout(MdTimeout), .StallCycles(StallCycles)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic              rst;
        logic              jump;
        logic [ADDR_W-1:0] jaddr;
        logic              load;
        logic [4:0]        rd;
        logic              rdWe;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              re1;
        logic              re2;
        logic              mdReq;
        logic              mdDone;
        logic              memReq;
        logic              memReady;
    } stim_t;

    // ctrl = {MdStartOut, StallPc, StallIf2Id, StallId2Ex, StallEx2Mem, FlushIf2Id,
    //         BubbleId2Ex, BubbleEx2Mem, BubbleMem2Wb, JumpFlagToPc, MdTimeout}
    typedef struct {
        logic [10:0]       ctrl;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  cnt;
        int                cyc;
    } exp_t;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatch = 0;
    int   cycleNo   = 0;

    // Reference model: phase 0 = idle, 1 = start pulse, 2 = busy.
    int   mdPhase    = 0;
    int   busyCnt    = 0;
    int   stallCnt   = 0;
    bit   mdTo       = 1'b0;
    bit   modelValid = 1'b0;

    function automatic exp_t expectFor(input stim_t s);
        exp_t e;
        bit memWait, loadUse, mdHold;
        bit sPc, sIf, sId, sEx, fl, bId, bEx, bWb, jf;
        memWait = s.memReq && !s.memReady;
        loadUse = s.load && s.rdWe && (s.rd != 5'd0) &&
                  ((s.re1 && s.rs1 == s.rd) || (s.re2 && s.rs2 == s.rd));
        mdHold  = (mdPhase != 0 || s.mdReq) && !(mdPhase == 2 && s.mdDone);
        {sPc, sIf, sId, sEx, fl, bId, bEx, bWb, jf} = 9'd0;
        e.addr = '0;
        if (memWait) begin
            {sPc, sIf, sId, sEx, bWb} = 5'b11111;
        end else if (mdHold) begin
            {sPc, sIf, sId, bEx} = 4'b1111;
        end else if (s.jump) begin
            {jf, fl, bId} = 3'b111;
            e.addr = s.jaddr;
        end else if (loadUse) begin
            {sPc, sIf, bId} = 3'b111;
        end
        e.ctrl = {(mdPhase == 1), sPc, sIf, sId, sEx, fl, bId, bEx, bWb, jf, mdTo};
        e.cnt  = CNT_W'(stallCnt);
        e.cyc  = cycleNo;
        return e;
    endfunction

    task automatic runCycle(input stim_t s);
        exp_t e;
        bit memWait;
        Rst = s.rst; JumpFlagFromEx = s.jump; JumpAddrFromEx = s.jaddr;
        LoadInEx = s.load; RdAddrEx = s.rd; RdWriteEnableEx = s.rdWe;
        Rs1AddrId = s.rs1; Rs2AddrId = s.rs2; Rs1ReadEnableId = s.re1; Rs2ReadEnableId = s.re2;
        MdReqEx = s.mdReq; MdDoneIn = s.mdDone; MemReqIn = s.memReq; MemReadyIn = s.memReady;
        e = expectFor(s);
        if (modelValid) expQ.push_back(e);
        memWait = s.memReq && !s.memReady;
        if (s.rst) begin
            mdPhase = 0; busyCnt = 0; stallCnt = 0; mdTo = 1'b0; modelValid = 1'b1;
        end else begin
            stallCnt = (stallCnt + int'(e.ctrl[9])) % (1 << CNT_W);
            if (mdPhase == 0) begin
                if (s.mdReq && !memWait) mdPhase = 1;
            end else if (mdPhase == 1) begin
                mdPhase = 2; busyCnt = 0;
            end else if (s.mdDone) begin
                mdPhase = 0;
            end else begin
                busyCnt++;
                if (busyCnt == MD_TIMEOUT) begin
                    mdTo = 1'b1; mdPhase = 0;
                end
            end
        end
        @(posedge Clk);
        #1;
        cycleNo++;
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    exp_t        monE;
    logic [10:0] actCtrl;
    always @(negedge Clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            actCtrl = {MdStartOut, StallPc, StallIf2Id, StallId2Ex, StallEx2Mem, FlushIf2Id,
                       BubbleId2Ex, BubbleEx2Mem, BubbleMem2Wb, JumpFlagToPc, MdTimeout};
            nCompared += 3;
            if (actCtrl !== monE.ctrl) begin
                nMismatch++;
                $display("FAIL ctrl cycle %0d: got %b expected %b", monE.cyc, actCtrl, monE.ctrl);
            end
            if (JumpAddrToPc !== monE.addr) begin
                nMismatch++;
                $display("FAIL jumpaddr cycle %0d: got %h expected %h", monE.cyc, JumpAddrToPc, monE.addr);
            end
            if (StallCycles !== monE.cnt) begin
                nMismatch++;
                $display("FAIL stallcycles cycle %0d: got %0d expected %0d", monE.cyc, StallCycles, monE.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        // reset, then idle
        s = '0; s.rst = 1'b1;
        runCycle(s); runCycle(s);
        s = '0; runCycle(s);
        // jump
        s = '0; s.jump = 1'b1; s.jaddr = 64'h0000_0000_8000_0040; runCycle(s);
        // load-use on rs2, then idle, then same pattern with rd = x0
        s = '0; s.load = 1'b1; s.rdWe = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.re2 = 1'b1; runCycle(s);
        s = '0; runCycle(s);
        s = '0; s.load = 1'b1; s.rdWe = 1'b1; s.rd = 5'd0; s.rs2 = 5'd0; s.re2 = 1'b1; runCycle(s);
        // mul/div with done four cycles after the start pulse
        s = '0; s.mdReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s.mdDone = (i == 5);
            runCycle(s);
        end
        s = '0; runCycle(s); runCycle(s);
        // mul/div timeout, then done in idle is ignored
        s = '0; s.mdReq = 1'b1;
        for (int i = 0; i < 10; i++) runCycle(s);
        s = '0;
        for (int i = 0; i < 4; i++) runCycle(s);
        s.mdDone = 1'b1; runCycle(s);
        // memory wait holding a jump for three cycles, jump taken on the fourth
        s = '0; s.memReq = 1'b1; s.jump = 1'b1; s.jaddr = 64'hDEAD_BEEF_1234_5678;
        for (int i = 0; i < 3; i++) runCycle(s);
        s.memReady = 1'b1; runCycle(s);
        // long memory wait wraps the stall counter
        s = '0; s.memReq = 1'b1;
        for (int i = 0; i < 260; i++) runCycle(s);
        s = '0; runCycle(s);
        // reset while busy
        s = '0; s.mdReq = 1'b1;
        for (int i = 0; i < 4; i++) runCycle(s);
        s.rst = 1'b1; runCycle(s);
        s = '0; runCycle(s); runCycle(s);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            s.rst      = ($urandom_range(0, 149) == 0);
            s.jump     = ($urandom_range(0, 3) == 0);
            s.jaddr    = {$urandom, $urandom};
            s.load     = ($urandom_range(0, 2) == 0);
            s.rd       = 5'($urandom_range(0, 7));
            s.rdWe     = ($urandom_range(0, 3) != 0);
            s.rs1      = 5'($urandom_range(0, 7));
            s.rs2      = 5'($urandom_range(0, 7));
            s.re1      = ($urandom_range(0, 1) == 0);
            s.re2      = ($urandom_range(0, 1) == 0);
            s.mdReq    = ($urandom_range(0, 5) == 0);
            s.mdDone   = ($urandom_range(0, 7) == 0);
            s.memReq   = ($urandom_range(0, 2) == 0);
            s.memReady = ($urandom_range(0, 1) == 0);
            runCycle(s);
        end
        @(negedge Clk);
        #1;
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatch++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
